// File: rtl/dpll_pkg.sv
// Shared DPLL definitions: controller states, literal width convention and
// the literal encoder used by both the pure-literal detector and emitter.
package dpll_pkg;

  // Widest variable index the encoder helper supports. Instances use
  // WIDTH < MaxWidth so the encoded result always has spare upper bits.
  localparam int unsigned MaxWidth = 32;
  localparam int unsigned MaxLitW  = MaxWidth + 1;

  // Literals carry one sign bit above the variable index.
  function automatic int unsigned lit_width(input int unsigned width);
    return width + 1;
  endfunction

  // Pure-literal emitter states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StEmit = 2'd2,
    StDone = 2'd3
  } emit_state_e;

  // Index plus polarity to a two's-complement signed literal. Callers keep
  // the low lit_width(WIDTH) bits; modular negation makes the truncation exact.
  function automatic logic [MaxLitW-1:0] encode_lit(input logic [MaxWidth-1:0] idx,
                                                    input logic              positive);
    logic [MaxLitW-1:0] mag;
    mag = {1'b0, idx};
    return positive ? mag : (MaxLitW'(0) - mag);
  endfunction

endpackage

// File: rtl/pure_literal_emitter.sv
// Pure-literal emitter: snapshots the positive/negative occurrence bitmaps on
// start, walks variables 1..OUT_SIZE-1 one per cycle and hands every variable
// seen in exactly one polarity downstream as a signed literal over a
// valid/ready handshake. Variable 0 is reserved and never visited.
module pure_literal_emitter
  import dpll_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned OUT_SIZE = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [OUT_SIZE-1:0]  pos_occ,
  input  logic [OUT_SIZE-1:0]  neg_occ,
  output logic [WIDTH:0]       literal_out,
  output logic                 literal_valid,
  input  logic                 literal_ready,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH:0]       pure_count
);

  localparam int unsigned LitW = lit_width(WIDTH);

  // Last variable slot; scanning stops after it.
  localparam logic [WIDTH-1:0] LastIdx  = WIDTH'(OUT_SIZE - 1);
  localparam logic [WIDTH-1:0] FirstIdx = WIDTH'(1);

  emit_state_e         state_q;
  logic [WIDTH-1:0]    idx_q;
  logic [OUT_SIZE-1:0] pos_snap_q;
  logic [OUT_SIZE-1:0] neg_snap_q;

  // Snapshot bits of the variable currently under the scan pointer.
  logic cur_pos;
  logic cur_neg;
  logic cur_pure;
  logic at_last;

  logic [MaxWidth-1:0] idx_ext;
  logic [MaxLitW-1:0]  lit_full;
  logic [LitW-1:0]     scan_lit;
  logic                unused_lit_hi;

  // Decode the scan pointer against the snapshot and pre-encode its literal.
  always_comb begin
    cur_pos  = pos_snap_q[idx_q];
    cur_neg  = neg_snap_q[idx_q];
    cur_pure = cur_pos ^ cur_neg;
    at_last  = (idx_q == LastIdx);
    idx_ext  = MaxWidth'(idx_q);
    lit_full = encode_lit(idx_ext, cur_pos);
    scan_lit = lit_full[LitW-1:0];
  end

  // Upper encoder bits are redundant sign extension.
  assign unused_lit_hi = ^lit_full[MaxLitW-1:LitW];

  // Scan controller; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      idx_q         <= FirstIdx;
      pos_snap_q    <= '0;
      neg_snap_q    <= '0;
      literal_out   <= '0;
      literal_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pure_count    <= '0;
    end else begin
      // done is a single-cycle pulse, raised only on the transition into StDone.
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            pos_snap_q <= pos_occ;
            neg_snap_q <= neg_occ;
            idx_q      <= FirstIdx;
            pure_count <= '0;
            busy       <= 1'b1;
            state_q    <= StScan;
          end
        end

        StScan: begin
          if (cur_pure) begin
            literal_out   <= scan_lit;
            literal_valid <= 1'b1;
            state_q       <= StEmit;
          end else if (at_last) begin
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + FirstIdx;
          end
        end

        StEmit: begin
          // literal_out/literal_valid hold until the handshake completes.
          if (literal_ready) begin
            literal_valid <= 1'b0;
            pure_count    <= pure_count + LitW'(1);
            if (at_last) begin
              done    <= 1'b1;
              state_q <= StDone;
            end else begin
              idx_q   <= idx_q + FirstIdx;
              state_q <= StScan;
            end
          end
        end

        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pure_literal_emitter.sv
// Directed bench for pure_literal_emitter at WIDTH=4, OUT_SIZE=16.
module tb_pure_literal_emitter;

  localparam int unsigned W = 4;
  localparam int unsigned N = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] pos_occ;
  logic [N-1:0] neg_occ;
  logic [W:0]   literal_out;
  logic         literal_valid;
  logic         literal_ready;
  logic         busy;
  logic         done;
  logic [W:0]   pure_count;

  int checks = 0;
  int passes = 0;

  // Results captured by run_scan.
  logic [W:0] lits[$];
  int         done_cyc;
  int         done_cnt;
  bit         unstable;
  bit         any_valid;
  logic       busy_at_done;

  pure_literal_emitter #(
    .WIDTH    (W),
    .OUT_SIZE (N)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .pos_occ       (pos_occ),
    .neg_occ       (neg_occ),
    .literal_out   (literal_out),
    .literal_valid (literal_valid),
    .literal_ready (literal_ready),
    .busy          (busy),
    .done          (done),
    .pure_count    (pure_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issue start with the given bitmaps and watch the scan. Cycle c is the
  // c-th clock period after the edge that sampled start. literal_ready is low
  // for cycles [hold_from, hold_from+hold_len). With disturb set the bitmaps
  // are scrambled and start is pulsed mid-scan. extra extends observation
  // past done to catch spurious pulses.
  task automatic run_scan(input logic [N-1:0] p, input logic [N-1:0] n, input int hold_from,
                          input int hold_len, input bit disturb, input int extra);
    logic [W:0] prev_lit;
    logic       prev_valid;
    logic       prev_ready;
    lits.delete();
    done_cyc     = -1;
    done_cnt     = 0;
    unstable     = 1'b0;
    any_valid    = 1'b0;
    busy_at_done = 1'b0;
    prev_valid   = 1'b0;
    prev_ready   = 1'b1;
    prev_lit     = '0;
    @(negedge clk);
    pos_occ       = p;
    neg_occ       = n;
    start         = 1'b1;
    literal_ready = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (disturb && c == 3) begin
        pos_occ = '1;
        neg_occ = '0;
        start   = 1'b1;
      end
      literal_ready = !(c >= hold_from && c < hold_from + hold_len);
      if (prev_valid && !prev_ready && (!literal_valid || literal_out !== prev_lit))
        unstable = 1'b1;
      if (literal_valid) begin
        any_valid = 1'b1;
        if (literal_ready) lits.push_back(literal_out);
      end
      prev_valid = literal_valid;
      prev_lit   = literal_out;
      prev_ready = literal_ready;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc     = c;
          busy_at_done = busy;
        end
      end
      if (done_cyc >= 0 && c >= done_cyc + extra) break;
    end
    start         = 1'b0;
    literal_ready = 1'b1;
  endtask

  initial begin
    logic [W:0] e;
    reset         = 1'b1;
    start         = 1'b0;
    pos_occ       = '0;
    neg_occ       = '0;
    literal_ready = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(literal_valid), 32'h0);
    check("rst_lit", 32'(literal_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_count", 32'(pure_count), 32'h0);
    reset = 1'b0;

    // Basic emission: +1 then -5, var 2 skipped.
    run_scan(16'h0006, 16'h0024, 0, 0, 1'b0, 3);
    check("basic_n", 32'(lits.size()), 32'd2);
    check("basic_l0", 32'(lits[0]), 32'h01);
    check("basic_l1", 32'(lits[1]), 32'h1B);
    check("basic_done_cyc", 32'(done_cyc), 32'd18);
    check("basic_done_cnt", 32'(done_cnt), 32'd1);
    check("basic_busy_done", 32'(busy_at_done), 32'h1);
    check("basic_count", 32'(pure_count), 32'd2);
    check("idle_busy", 32'(busy), 32'h0);

    // Backpressure on +1 for 5 cycles.
    run_scan(16'h0006, 16'h0024, 2, 5, 1'b0, 0);
    check("bp_n", 32'(lits.size()), 32'd2);
    check("bp_l0", 32'(lits[0]), 32'h01);
    check("bp_l1", 32'(lits[1]), 32'h1B);
    check("bp_stable", 32'(unstable), 32'h0);
    check("bp_done_cyc", 32'(done_cyc), 32'd23);
    check("bp_count", 32'(pure_count), 32'd2);

    // All pure, alternating polarity: +1, -2, +3, ... +15.
    run_scan(16'hAAAA, 16'h5554, 0, 0, 1'b0, 0);
    check("all_n", 32'(lits.size()), 32'd15);
    for (int i = 1; i <= 15; i++) begin
      e = 5'(i);
      if (!i[0]) e = 5'(0) - e;
      check($sformatf("all_l%0d", i), 32'(lits[i-1]), 32'(e));
    end
    check("all_done_cyc", 32'(done_cyc), 32'd31);
    check("all_count", 32'(pure_count), 32'd15);

    // Empty scan with only reserved slot 0 set, started back-to-back.
    run_scan(16'h0001, 16'h0000, 0, 0, 1'b0, 2);
    check("empty_valid", 32'(any_valid), 32'h0);
    check("empty_done_cyc", 32'(done_cyc), 32'd16);
    check("empty_count", 32'(pure_count), 32'd0);

    // Reset while +1 is pending.
    @(negedge clk);
    pos_occ = 16'h0006;
    neg_occ = 16'h0024;
    start   = 1'b1;
    @(negedge clk);
    start         = 1'b0;
    literal_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", 32'(literal_valid), 32'h1);
    check("pre_rst_lit", 32'(literal_out), 32'h01);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 32'(literal_valid), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_count", 32'(pure_count), 32'd0);
    check("mid_rst_lit", 32'(literal_out), 32'h0);
    reset         = 1'b0;
    literal_ready = 1'b1;

    run_scan(16'h0006, 16'h0024, 0, 0, 1'b0, 0);
    check("rerun_n", 32'(lits.size()), 32'd2);
    check("rerun_l0", 32'(lits[0]), 32'h01);
    check("rerun_l1", 32'(lits[1]), 32'h1B);
    check("rerun_done_cyc", 32'(done_cyc), 32'd18);

    // Snapshot immunity: bitmaps change and start pulses mid-scan.
    run_scan(16'h0006, 16'h0024, 0, 0, 1'b1, 20);
    check("snap_n", 32'(lits.size()), 32'd2);
    check("snap_l0", 32'(lits[0]), 32'h01);
    check("snap_l1", 32'(lits[1]), 32'h1B);
    check("snap_done_cyc", 32'(done_cyc), 32'd18);
    check("snap_done_cnt", 32'(done_cnt), 32'd1);
    check("snap_count", 32'(pure_count), 32'd2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
